// File: rtl/sumador_mac.sv
// sumador_mac: accumulates TERMS signed terms onto a loaded offset.
// Every addition saturates, so no partial sum ever wraps around.
// Suma_G and Sat are registered on the edge that accepts the last term.
// Listo and Ocupado are decoded from the registered FSM state.
module sumador_mac #(
    parameter int N     = 24,
    parameter int TERMS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Iniciar,
    input  logic signed [N-1:0] Sum_ext,
    input  logic                Valido_in,
    input  logic signed [N-1:0] Multiplica,
    output logic signed [N-1:0] Suma_G,
    output logic                Listo,
    output logic                Ocupado,
    output logic                Sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACUM = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic signed [N-1:0] MAX_VAL  = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MIN_VAL  = {1'b1, {(N-1){1'b0}}};
    localparam logic [7:0]          LAST_CNT = 8'(TERMS - 1);

    state_t              state;
    state_t              state_nxt;
    logic signed [N-1:0] acc;
    logic [7:0]          count;
    logic                sat_run;

    logic signed [N-1:0] add_res_p0;
    logic                add_ovf_p0;
    logic                last_term_p0;

    // Add at N+1 bits, then clamp to the N-bit range; MSB of the return flags a clamp.
    function automatic logic [N:0] sat_add(input logic signed [N-1:0] a,
                                           input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N:N-1] == 2'b01) begin
            sat_add = {1'b1, MAX_VAL};
        end else if (s[N:N-1] == 2'b10) begin
            sat_add = {1'b1, MIN_VAL};
        end else begin
            sat_add = {1'b0, s[N-1:0]};
        end
    endfunction

    // Saturated candidate sum and last-term detection for the current cycle.
    always_comb begin
        {add_ovf_p0, add_res_p0} = sat_add(acc, Multiplica);
        last_term_p0             = Valido_in && (count == LAST_CNT);
    end

    // Next-state logic: a restart from ACUM re-enters ACUM; FIN always drains to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Iniciar) state_nxt = ACUM;
            end
            ACUM: begin
                if (Iniciar)           state_nxt = ACUM;
                else if (last_term_p0) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, accumulator and result registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            sat_run <= 1'b0;
            Suma_G  <= '0;
            Sat     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (Iniciar) begin
                        acc     <= Sum_ext;
                        count   <= '0;
                        sat_run <= 1'b0;
                    end
                end
                ACUM: begin
                    if (Iniciar) begin
                        acc     <= Sum_ext;
                        count   <= '0;
                        sat_run <= 1'b0;
                    end else if (Valido_in) begin
                        acc     <= add_res_p0;
                        count   <= count + 8'd1;
                        sat_run <= sat_run | add_ovf_p0;
                        // Publish on the accepting edge so the result is ready alongside Listo.
                        if (last_term_p0) begin
                            Suma_G <= add_res_p0;
                            Sat    <= sat_run | add_ovf_p0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status strobes decoded from the registered state.
    always_comb begin
        Listo   = (state == FIN);
        Ocupado = (state != IDLE);
    end

endmodule

// File: tb/tb_sumador_mac.sv
// Directed-vector bench for sumador_mac (N=24, TERMS=5).
module tb_sumador_mac;

    logic               clk = 1'b0;
    logic               reset;
    logic               Iniciar;
    logic signed [23:0] Sum_ext;
    logic               Valido_in;
    logic signed [23:0] Multiplica;
    logic signed [23:0] Suma_G;
    logic               Listo;
    logic               Ocupado;
    logic               Sat;

    int errors = 0;
    int checks = 0;

    sumador_mac #(.N(24), .TERMS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .Iniciar   (Iniciar),
        .Sum_ext   (Sum_ext),
        .Valido_in (Valido_in),
        .Multiplica(Multiplica),
        .Suma_G    (Suma_G),
        .Listo     (Listo),
        .Ocupado   (Ocupado),
        .Sat       (Sat)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic signed [23:0] v);
        Iniciar = 1'b1;
        Sum_ext = v;
        cyc();
        Iniciar = 1'b0;
        Sum_ext = 24'sd0;
    endtask

    task automatic term(input logic signed [23:0] v);
        Valido_in  = 1'b1;
        Multiplica = v;
        cyc();
        Valido_in  = 1'b0;
        Multiplica = 24'sd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        checks++;
        if (Suma_G !== 24'sd0 || Sat !== 1'b0 || Listo !== 1'b0 || Ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got Suma_G=%0d Sat=%b Listo=%b Ocupado=%b, want 0 0 0 0",
                     Suma_G, Sat, Listo, Ocupado);
        end
        // Valid terms while idle must not start anything.
        term(24'sd9);
        term(24'sd9);
        checks++;
        if (Ocupado !== 1'b0 || Listo !== 1'b0 || Suma_G !== 24'sd0) begin
            errors++;
            $display("FAIL idle_valid: got Ocupado=%b Listo=%b Suma_G=%0d, want 0 0 0",
                     Ocupado, Listo, Suma_G);
        end
    endtask

    task automatic test_basic();
        start(24'sd100);
        checks++;
        if (Ocupado !== 1'b1 || Listo !== 1'b0) begin
            errors++;
            $display("FAIL basic_start: got Ocupado=%b Listo=%b, want 1 0", Ocupado, Listo);
        end
        term(24'sd1);
        term(24'sd2);
        term(24'sd3);
        term(24'sd4);
        checks++;
        if (Listo !== 1'b0 || Ocupado !== 1'b1) begin
            errors++;
            $display("FAIL basic_early_listo: got Listo=%b Ocupado=%b, want 0 1", Listo, Ocupado);
        end
        term(24'sd5);
        checks++;
        if (Listo !== 1'b1 || Suma_G !== 24'sd115 || Sat !== 1'b0 || Ocupado !== 1'b1) begin
            errors++;
            $display("FAIL basic_result: got Listo=%b Suma_G=%0d Sat=%b Ocupado=%b, want 1 115 0 1",
                     Listo, Suma_G, Sat, Ocupado);
        end
        // Iniciar during FIN is ignored; the block returns to idle.
        Iniciar = 1'b1;
        Sum_ext = 24'sd999;
        cyc();
        Iniciar = 1'b0;
        checks++;
        if (Listo !== 1'b0 || Ocupado !== 1'b0 || Suma_G !== 24'sd115) begin
            errors++;
            $display("FAIL fin_iniciar: got Listo=%b Ocupado=%b Suma_G=%0d, want 0 0 115",
                     Listo, Ocupado, Suma_G);
        end
    endtask

    task automatic test_gaps();
        start(24'sd100);
        term(24'sd1);
        term(24'sd2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (Ocupado !== 1'b1 || Listo !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold[%0d]: got Ocupado=%b Listo=%b, want 1 0", i, Ocupado, Listo);
            end
        end
        term(24'sd3);
        term(24'sd4);
        term(24'sd5);
        checks++;
        if (Listo !== 1'b1 || Suma_G !== 24'sd115 || Sat !== 1'b0) begin
            errors++;
            $display("FAIL gap_result: got Listo=%b Suma_G=%0d Sat=%b, want 1 115 0", Listo, Suma_G, Sat);
        end
        cyc();
    endtask

    task automatic test_sat_pos();
        start(24'sd8388600);
        term(24'sd5);
        term(24'sd5);
        term(-24'sd1);
        term(-24'sd1);
        term(-24'sd1);
        checks++;
        if (Listo !== 1'b1 || Suma_G !== 24'sd8388604 || Sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: got Listo=%b Suma_G=%0d Sat=%b, want 1 8388604 1", Listo, Suma_G, Sat);
        end
        cyc();
    endtask

    task automatic test_abort();
        start(24'sd0);
        term(24'sd1);
        term(24'sd1);
        term(24'sd1);
        start(24'sd7);
        checks++;
        if (Listo !== 1'b0 || Ocupado !== 1'b1 || Suma_G !== 24'sd8388604 || Sat !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold: got Listo=%b Ocupado=%b Suma_G=%0d Sat=%b, want 0 1 8388604 1",
                     Listo, Ocupado, Suma_G, Sat);
        end
        for (int i = 0; i < 4; i++) begin
            term(24'sd1);
            checks++;
            if (Listo !== 1'b0 || Suma_G !== 24'sd8388604) begin
                errors++;
                $display("FAIL abort_early[%0d]: got Listo=%b Suma_G=%0d, want 0 8388604", i, Listo, Suma_G);
            end
        end
        term(24'sd1);
        checks++;
        if (Listo !== 1'b1 || Suma_G !== 24'sd12 || Sat !== 1'b0) begin
            errors++;
            $display("FAIL abort_result: got Listo=%b Suma_G=%0d Sat=%b, want 1 12 0", Listo, Suma_G, Sat);
        end
        cyc();
    endtask

    task automatic test_sat_neg();
        logic signed [23:0] exp_min;
        exp_min = -24'sd8388608;
        start(-24'sd8388600);
        term(-24'sd10);
        for (int i = 0; i < 4; i++) term(24'sd0);
        checks++;
        if (Listo !== 1'b1 || Suma_G !== exp_min || Sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: got Listo=%b Suma_G=%0d Sat=%b, want 1 %0d 1", Listo, Suma_G, Sat, exp_min);
        end
        cyc();
        // Back-to-back run; prior result held until the new Listo.
        start(24'sd0);
        for (int i = 0; i < 4; i++) term(24'sd0);
        checks++;
        if (Suma_G !== exp_min || Sat !== 1'b1 || Listo !== 1'b0) begin
            errors++;
            $display("FAIL hold_between: got Suma_G=%0d Sat=%b Listo=%b, want %0d 1 0", Suma_G, Sat, Listo, exp_min);
        end
        term(24'sd0);
        checks++;
        if (Listo !== 1'b1 || Suma_G !== 24'sd0 || Sat !== 1'b0) begin
            errors++;
            $display("FAIL zero_run: got Listo=%b Suma_G=%0d Sat=%b, want 1 0 0", Listo, Suma_G, Sat);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        // Leave a nonzero result so the reset clear is observable.
        start(24'sd100);
        for (int i = 1; i <= 5; i++) term(24'(i));
        cyc();
        start(24'sd50);
        term(24'sd3);
        term(24'sd4);
        reset      = 1'b1;
        Iniciar    = 1'b1;
        Valido_in  = 1'b1;
        Multiplica = 24'sd5;
        cyc();
        reset     = 1'b0;
        Iniciar   = 1'b0;
        Valido_in = 1'b0;
        checks++;
        if (Suma_G !== 24'sd0 || Sat !== 1'b0 || Listo !== 1'b0 || Ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got Suma_G=%0d Sat=%b Listo=%b Ocupado=%b, want 0 0 0 0",
                     Suma_G, Sat, Listo, Ocupado);
        end
        cyc();
        cyc();
        checks++;
        if (Listo !== 1'b0 || Ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_listo: got Listo=%b Ocupado=%b, want 0 0", Listo, Ocupado);
        end
        start(24'sd100);
        for (int i = 1; i <= 5; i++) term(24'(i));
        checks++;
        if (Listo !== 1'b1 || Suma_G !== 24'sd115 || Sat !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got Listo=%b Suma_G=%0d Sat=%b, want 1 115 0", Listo, Suma_G, Sat);
        end
        cyc();
    endtask

    initial begin
        reset      = 1'b1;
        Iniciar    = 1'b0;
        Sum_ext    = 24'sd0;
        Valido_in  = 1'b0;
        Multiplica = 24'sd0;
        test_reset();
        test_basic();
        test_gaps();
        test_sat_pos();
        test_abort();
        test_sat_neg();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
